mc_traffic_gen: RTL and testbench
=================================

MC_TRAFFIC_GEN -- requirements
Module: mc_traffic_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of request and read data.
REQ-002 Parameter ADDR_WIDTH, default 30, width of request address.
REQ-003 Parameter CNT_WIDTH, default 16, width of request-count and error counters.
REQ-004 Parameter TIMEOUT, default 200, maximum idle cycles without read_done while reads are outstanding.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse that launches a test run; sampled only in IDLE.
REQ-008 num_requests  input  CNT_WIDTH  number of writes, and also reads, per run; sampled with start.
REQ-009 seed  input  DATA_WIDTH  data pattern offset; sampled with start.
REQ-010 out_busy  input  1  controller cannot accept a request this cycle.
REQ-011 in_valid  output  1  request present toward the controller.
REQ-012 in_request_type  output  1  1 = write, 0 = read.
REQ-013 in_request_address  output  ADDR_WIDTH  request address.
REQ-014 in_request_data  output  DATA_WIDTH  write data; don't-care for reads.
REQ-015 read_done  input  1  controller returns one read beat this cycle.
REQ-016 data_out  input  DATA_WIDTH  returned read data, valid when read_done=1.
REQ-017 busy  output  1  a run is in progress (state is not IDLE or DONE).
REQ-018 done  output  1  held high in DONE until the next start.
REQ-019 timeout  output  1  the run ended by timeout; valid while done=1.
REQ-020 error_count  output  CNT_WIDTH  number of data mismatches plus unexpected beats; saturates at all-ones.

Function
REQ-021 A request SHALL transfer on a rising edge where in_valid=1 and out_busy=0; while out_busy=1, all request outputs SHALL be held stable.
REQ-022 The FSM SHALL have states IDLE, WRITE, READ, DRAIN and DONE.
REQ-023 IDLE/DONE + start: if num_requests=0, go to DONE with timeout=0; otherwise go to WRITE and clear the address counter, return counter, error_count, timeout and the idle timer.
REQ-024 WRITE: in_valid=1, type=1, address = write index i (zero-extended), data = i[DATA_WIDTH-1:0] + seed, modulo 2^DATA_WIDTH; i increments on each transfer.
REQ-025 After write index num_requests-1 transfers, the FSM SHALL enter READ with the index reset to 0.
REQ-026 In the cycle after the last write, in_valid SHALL already carry read 0, with no bubble cycle.
REQ-027 READ: in_valid=1, type=0, address = read index; after read num_requests-1 transfers, go to DRAIN with in_valid=0.
REQ-028 Return checking: each read_done SHALL be compared with expected = r + seed, where r is the return counter; on mismatch error_count increments; r increments on every read_done.
REQ-029 Read data SHALL be assumed in issue order; the block SHALL NOT reorder.
REQ-030 read_done is accepted in READ and DRAIN; read_done in IDLE, WRITE or DONE, or when r already equals num_requests, SHALL increment error_count and SHALL NOT advance r.
REQ-031 DRAIN: when r reaches num_requests, go to DONE with timeout=0.
REQ-032 Idle timer: in READ and DRAIN it SHALL clear on read_done, otherwise increment; on reaching TIMEOUT it SHALL force DONE with timeout=1.
REQ-033 A matching read_done and the TIMEOUT condition in the same cycle SHALL give read_done priority, and the timer clears.
REQ-034 A start pulse while busy=1 SHALL be ignored.
REQ-035 Counters SHALL wrap only at their own width; error_count SHALL saturate.

Reset
REQ-036 When rst_n=0, the block SHALL immediately enter IDLE with in_valid=0, in_request_type=0, address=0, data=0, busy=0, done=0, timeout=0, error_count=0 and all counters at 0.
REQ-037 A reset asserted mid-run SHALL abort the run with no further requests; after release the block waits in IDLE for start.

Verification
REQ-038 num_requests=4, seed=0x10, out_busy=0, ideal memory echo -> writes to addr 0..3 with data 0x10..0x13, then reads 0..3, done=1, error_count=0, timeout=0.
REQ-039 out_busy=1 for 5 cycles mid-write -> outputs stable throughout and no duplicate or skipped address.
REQ-040 Memory returns 0xFFFF for read 2 -> error_count=1 and done=1.
REQ-041 No read_done after the last read -> done and timeout=1 exactly TIMEOUT cycles after the last issued or returned beat.
REQ-042 num_requests=0 with start -> done=1 the next cycle and in_valid never asserted.
REQ-043 rst_n pulsed low during READ -> in_valid=0 immediately and state IDLE; a following start with num_requests=2 completes cleanly.

Source files
------------

// File: rtl/mc_traffic_gen.sv
// Memory-controller traffic generator: writes a seeded ramp, reads it back in
// issue order, and counts data mismatches and unexpected read beats.
module mc_traffic_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 30,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_requests,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  out_busy,
  output logic                  in_valid,
  output logic                  in_request_type,
  output logic [ADDR_WIDTH-1:0] in_request_address,
  output logic [DATA_WIDTH-1:0] in_request_data,
  input  logic                  read_done,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  error_count
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  idx;
  logic [CNT_WIDTH-1:0]  ret_cnt;
  logic [CNT_WIDTH-1:0]  nreq_q;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [TMR_W-1:0]      tmr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [CNT_WIDTH-1:0] i,
                                                    input logic [DATA_WIDTH-1:0] s);
    return DATA_WIDTH'(i) + s;
  endfunction

  logic                 xfer, last_idx, rd_phase, beat_ok, ret_match, ret_last, tmr_hit;
  logic [CNT_WIDTH-1:0] idx_inc;
  logic [TMR_W-1:0]     tmr_inc;

  assign xfer      = in_valid && !out_busy;
  assign idx_inc   = idx + CNT_WIDTH'(1);
  assign last_idx  = (idx == nreq_q - CNT_WIDTH'(1));
  assign rd_phase  = (state == S_READ) || (state == S_DRAIN);
  // A beat only counts as a return while reads are owed; anything else is an error.
  assign beat_ok   = read_done && rd_phase && (ret_cnt != nreq_q);
  assign ret_match = (data_out == pattern(ret_cnt, seed_q));
  assign ret_last  = beat_ok && (ret_cnt + CNT_WIDTH'(1) == nreq_q);
  assign tmr_inc   = tmr + TMR_W'(1);
  assign tmr_hit   = !read_done && (tmr_inc == TMR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      in_valid           <= 1'b0;
      in_request_type    <= 1'b0;
      in_request_address <= '0;
      in_request_data    <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      timeout            <= 1'b0;
      error_count        <= '0;
      idx                <= '0;
      ret_cnt            <= '0;
      nreq_q             <= '0;
      seed_q             <= '0;
      tmr                <= '0;
    end else begin
      if (read_done) begin
        if (beat_ok) begin
          ret_cnt <= ret_cnt + CNT_WIDTH'(1);
          if (!ret_match) error_count <= sat_inc(error_count);
        end else begin
          error_count <= sat_inc(error_count);
        end
      end
      if (rd_phase) tmr <= read_done ? '0 : tmr_inc;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            nreq_q  <= num_requests;
            seed_q  <= seed;
            timeout <= 1'b0;
            if (num_requests == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state              <= S_WRITE;
              busy               <= 1'b1;
              done               <= 1'b0;
              idx                <= '0;
              ret_cnt            <= '0;
              error_count        <= '0;
              tmr                <= '0;
              in_valid           <= 1'b1;
              in_request_type    <= 1'b1;
              in_request_address <= '0;
              in_request_data    <= seed;
            end
          end
        end
        S_WRITE: begin
          if (xfer) begin
            if (last_idx) begin
              // Read 0 is presented straight away so the bus sees no bubble.
              state              <= S_READ;
              idx                <= '0;
              in_request_type    <= 1'b0;
              in_request_address <= '0;
            end else begin
              idx                <= idx_inc;
              in_request_address <= ADDR_WIDTH'(idx_inc);
              in_request_data    <= pattern(idx_inc, seed_q);
            end
          end
        end
        S_READ: begin
          if (xfer) begin
            if (last_idx) begin
              state    <= S_DRAIN;
              idx      <= '0;
              in_valid <= 1'b0;
            end else begin
              idx                <= idx_inc;
              in_request_address <= ADDR_WIDTH'(idx_inc);
            end
          end
          if (tmr_hit) begin
            state    <= S_DONE;
            in_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (ret_last || ret_cnt == nreq_q) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tmr_hit) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_traffic_gen.sv
// Scoreboard bench for mc_traffic_gen: expected request streams are queued at
// start, a memory model answers reads, and a monitor checks every transfer.
module tb_mc_traffic_gen;
  localparam int DW = 16;
  localparam int AW = 30;
  localparam int CW = 16;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_requests = '0;
  logic [DW-1:0] seed = '0;
  logic          out_busy = 1'b0;
  logic          read_done = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          in_valid, in_request_type, busy, done, timeout;
  logic [AW-1:0] in_request_address;
  logic [DW-1:0] in_request_data;
  logic [CW-1:0] error_count;

  mc_traffic_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_requests(num_requests), .seed(seed),
    .out_busy(out_busy), .in_valid(in_valid), .in_request_type(in_request_type),
    .in_request_address(in_request_address), .in_request_data(in_request_data),
    .read_done(read_done), .data_out(data_out), .busy(busy), .done(done),
    .timeout(timeout), .error_count(error_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic typ; logic [AW-1:0] addr; logic [DW-1:0] data;} req_t;
  typedef struct {int due; logic [DW-1:0] data; bit drop;} ret_t;

  req_t          exp_q[$];
  ret_t          ret_q[$];
  logic [DW-1:0] mem [0:255];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            rand_busy = 0;
  int            busy_hold = 0;
  int            corrupt_idx = -1;
  logic [DW-1:0] corrupt_val = '0;
  bit            drop_last = 0;
  int            cur_n = 0;
  int            last_rd_cyc = 0;
  bit            inject_rd = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Controller-side drivers: back-pressure and in-order read returns.
  initial forever begin
    ret_t r;
    @(posedge clk);
    #1;
    if (busy_hold > 0) begin
      out_busy = 1'b1;
      busy_hold--;
    end else begin
      out_busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    read_done = 1'b0;
    if (inject_rd) begin
      read_done = 1'b1;
      data_out  = DW'($urandom);
      inject_rd = 0;
    end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      if (!r.drop) begin
        read_done   = 1'b1;
        data_out    = r.data;
        last_rd_cyc = cyc;
      end
    end
  end

  // Monitor: every transfer is matched against the head of the expected queue.
  initial begin
    bit   stall_prev;
    req_t prev, e, cur;
    ret_t r;
    stall_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0;
      end else begin
        cur.typ = in_request_type; cur.addr = in_request_address; cur.data = in_request_data;
        if (stall_prev) begin
          check("hold_valid", in_valid, 1);
          check("hold_type", cur.typ, prev.typ);
          check("hold_addr", cur.addr, prev.addr);
          check("hold_data", cur.data, prev.data);
        end
        if (in_valid && !out_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req actual_addr=%0h type=%0d required=none", cur.addr, cur.typ);
          end else begin
            e = exp_q.pop_front();
            check("req_type", cur.typ, e.typ);
            check("req_addr", cur.addr, e.addr);
            if (e.typ) check("req_data", cur.data, e.data);
          end
          if (cur.typ) begin
            mem[cur.addr[7:0]] = cur.data;
          end else begin
            r.due  = cyc + $urandom_range(1, 3);
            r.data = (int'(cur.addr) == corrupt_idx) ? corrupt_val : mem[cur.addr[7:0]];
            r.drop = drop_last && (int'(cur.addr) == cur_n - 1);
            ret_q.push_back(r);
          end
        end
        stall_prev = in_valid && out_busy;
        prev = cur;
      end
    end
  end

  task automatic load_expected(input int n, input logic [DW-1:0] s);
    req_t q;
    exp_q.delete();
    ret_q.delete();
    for (int i = 0; i < n; i++) begin
      q.typ = 1'b1; q.addr = AW'(i); q.data = DW'(i) + s;
      exp_q.push_back(q);
    end
    for (int i = 0; i < n; i++) begin
      q.typ = 1'b0; q.addr = AW'(i); q.data = '0;
      exp_q.push_back(q);
    end
  endtask

  task automatic run(input int n, input logic [DW-1:0] s, input bit rb, input bit hold5,
                     input int cidx, input logic [DW-1:0] cval, input bit drop);
    int exp_err, waited;
    bit got;
    load_expected(n, s);
    rand_busy = rb; corrupt_idx = cidx; corrupt_val = cval; drop_last = drop; cur_n = n;
    exp_err = (cidx >= 0 && cidx < n && cval !== DW'(cidx) + s) ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b1; num_requests = CW'(n); seed = s;
    @(posedge clk); #1;
    start = 1'b0; num_requests = CW'($urandom); seed = DW'($urandom);
    if (hold5) busy_hold = 5;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waited = 0; got = 0;
    while (waited < 3000 && !got) begin
      @(negedge clk);
      waited++;
      got = done;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL run_done_wait actual=no_done required=done_within_3000");
    end else begin
      check("run_timeout", timeout, drop);
      check("run_errors", error_count, exp_err);
      check("run_busy", busy, 0);
      check("run_all_issued", exp_q.size(), 0);
      if (drop) check("timeout_latency", cyc - last_rd_cyc, TO + 1);
    end
    rand_busy = 0;
  endtask

  initial begin
    int n, waited;
    logic [CW-1:0] ec;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", in_valid, 0);
    check("rst_type", in_request_type, 0);
    check("rst_addr", in_request_address, 0);
    check("rst_data", in_request_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_errcnt", error_count, 0);
    rst_n = 1'b1;

    // Zero-length run: done the next cycle, no request ever issued.
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b1; num_requests = '0; seed = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_timeout", timeout, 0);
    check("zero_busy", busy, 0);
    repeat (4) @(negedge clk);

    run(4, 16'h0010, 0, 0, -1, '0, 0);
    run(8, 16'h0100, 0, 1, -1, '0, 0);
    run(4, 16'h0010, 0, 0, 2, 16'hFFFF, 0);
    check("corrupt_done", done, 1);

    // A stray beat outside a run is counted as an error.
    ec = error_count;
    @(posedge clk); #2 inject_rd = 1;
    repeat (3) @(negedge clk);
    check("stray_beat_err", error_count, ec + 1);
    check("stray_done_held", done, 1);

    run(5, DW'($urandom), 0, 0, -1, '0, 1);
    run(3, 16'hFFFE, 1, 0, -1, '0, 0);
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(2, 20);
      run(n, DW'($urandom), 1, 0, $urandom_range(0, n + 3), DW'($urandom), 0);
    end

    // Reset in the middle of the read phase aborts cleanly.
    load_expected(6, 16'h0055);
    rand_busy = 0; corrupt_idx = -1; drop_last = 0; cur_n = 6;
    @(posedge clk); #1;
    start = 1'b1; num_requests = 6; seed = 16'h0055;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (waited < 100 && !(in_valid && !in_request_type)) begin
      @(negedge clk);
      waited++;
    end
    check("rst_mid_reached_read", in_valid && !in_request_type, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", in_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_errcnt", error_count, 0);
    exp_q.delete();
    ret_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_valid", in_valid, 0);
    run(2, 16'h0007, 0, 0, -1, '0, 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
